sincronizador_vga: RTL and testbench
====================================

Name: sincronizador_vga

Overview:
- Timing generator that drives the pixel-rendering side of the VGA path.
- Divides the system clock down to a pixel rate and runs horizontal and vertical position counters.
- Produces hsync/vsync plus the pixel_x, pixel_y and video_encendido signals consumed by the figure/renderer blocks (e.g. the tic-tac-toe board drawer).
- Sits between the board clock and the renderer; the renderer's salida_rgb is gated externally with these syncs.

Parameters:
- DIV, 2: system clocks per pixel (>=2); 50 MHz clk gives a 25 MHz pixel rate.
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VIS, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_encendido  out  1  high while the current pixel is in the visible area.
- pixel_tick  out  1  one-clk pulse in the last clk of each pixel period.
- pixel_x  out  11  current column, 0..H_TOTAL-1.
- pixel_y  out  11  current row, 0..V_TOTAL-1.
- fin_cuadro  out  1  only present with VGA_FIN_CUADRO_EN (see Optional Feature).

Behaviour:
- Derived constants:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
  - Both must be ≤2048. All counters are 11 bits unsigned; no negative arithmetic.
- Divider:
  - d counts 0..DIV-1 and wraps; it advances every clk.
  - A pixel period is DIV clks.
- Position advance, on the edge where d==DIV-1:
  - pixel_x increments.
  - If pixel_x==H_TOTAL-1, pixel_x wraps to 0 and pixel_y increments.
  - If that wrap also occurs with pixel_y==V_TOTAL-1, pixel_y wraps to 0.
  - Both wraps happen on the same edge; there are no intermediate values.
- All outputs are registered and mutually aligned:
  - hsync, vsync, video_encendido and pixel_tick are registered from the next-state values of d, pixel_x and pixel_y.
  - Every output therefore describes the same pixel in the same clk. No extra pipeline latency exists between position and decode.
- Decode, for the pixel currently on the outputs:
  - video_encendido = (pixel_x < H_VIS) && (pixel_y < V_VIS).
  - hsync = 0 iff H_VIS+H_FP ≤ pixel_x ≤ H_VIS+H_FP+H_SYNC-1 (656..751).
  - vsync = 0 iff V_VIS+V_FP ≤ pixel_y ≤ V_VIS+V_FP+V_SYNC-1 (490..491). vsync changes only together with pixel_y, i.e. at line start.
  - pixel_tick = 1 iff d==DIV-1.
- Reset values (held while reset=1, applied on the edge):
  - d=0, pixel_x=0, pixel_y=0.
  - hsync=1, vsync=1, video_encendido=1, pixel_tick=0, fin_cuadro=0.
  - These values equal the decode of position (0,0).
- Reset mid-operation:
  - Takes effect on the next edge regardless of position, syncs or divider phase.
  - If a sync pulse was active, it is truncated to 1 immediately.
  - The first clk after release shows pixel (0,0) with d=0. The first pixel advance occurs DIV clks after release.
- There are no inputs other than clk and reset, and no simultaneous-event cases beyond the wraps above.

Optional Feature:
- Macro: VGA_FIN_CUADRO_EN.
- Defined:
  - Adds output port fin_cuadro (1 bit, registered).
  - fin_cuadro = 1 for exactly one clk, the clk where pixel_tick=1 while pixel_x==H_TOTAL-1 and pixel_y==V_TOTAL-1.
  - The next edge shows (0,0).
  - Renderers use it to update game state between frames.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 5 clks, then released → during and right after reset: pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_encendido=1. First pixel_tick at clk DIV-1 after release (clk 1 for DIV=2). pixel_x=1 at clk 2.
- Free run one line, DIV=2 → pixel_x returns to 0 after exactly 1600 clks. hsync low for 192 consecutive clks, starting when pixel_x=656. video_encendido low from pixel_x=640 to 799.
- Free run one frame → pixel_y wraps 524→0 after 840000 clks. vsync low for 1600 pixel periods (3200 clks) covering pixel_y 490–491. video_encendido never high with pixel_y≥480. 307200 visible pixel_ticks per frame.
- Wrap corner → at (799,524) with pixel_tick=1, the next edge gives (0,0), hsync=1, vsync=1, video_encendido=1.
- Assert reset at (700,491), inside both sync pulses → next edge gives hsync=1, vsync=1, (0,0). Timing from release matches the first scenario.
- With VGA_FIN_CUADRO_EN → exactly one fin_cuadro pulse per 840000 clks, coincident with pixel_tick at (799,524). Without the macro, elaboration shows no fin_cuadro port.

Source files
------------

// File: rtl/sincronizador_vga.sv
// VGA timing generator: pixel-rate divider, x/y position counters and registered sync/visible decode.
// Optional frame-end strobe output fin_cuadro is built only when VGA_FIN_CUADRO_EN is defined.
module sincronizador_vga #(
  parameter int DIV    = 2,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        video_encendido,
  output logic        pixel_tick,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y
`ifdef VGA_FIN_CUADRO_EN
  ,
  output logic        fin_cuadro
`endif
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] D_LAST   = DW'(DIV - 1);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_VIS_L  = 11'(H_VIS);
  localparam logic [10:0]   V_VIS_L  = 11'(V_VIS);
  localparam logic [10:0]   HS_FIRST = 11'(H_VIS + H_FP);
  localparam logic [10:0]   HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0]   VS_FIRST = 11'(V_VIS + V_FP);
  localparam logic [10:0]   VS_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] d_q, d_d;
  logic [10:0]   pixel_x_q, pixel_x_d;
  logic [10:0]   pixel_y_q, pixel_y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_q, video_d;
  logic          tick_q, tick_d;

  // Decode is taken from the next-state position so every output flop
  // describes the same pixel as the position flops in the same clk.
  always_comb begin
    d_d       = (d_q == D_LAST) ? '0 : d_q + DW'(1);
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (d_q == D_LAST) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = '0;
        pixel_y_d = (pixel_y_q == V_LAST) ? 11'd0 : pixel_y_q + 11'd1;
      end else begin
        pixel_x_d = pixel_x_q + 11'd1;
      end
    end
    hsync_d = !((pixel_x_d >= HS_FIRST) && (pixel_x_d <= HS_LAST));
    vsync_d = !((pixel_y_d >= VS_FIRST) && (pixel_y_d <= VS_LAST));
    video_d = (pixel_x_d < H_VIS_L) && (pixel_y_d < V_VIS_L);
    tick_d  = (d_d == D_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q       <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      video_q   <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      d_q       <= d_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      video_q   <= video_d;
      tick_q    <= tick_d;
    end
  end

  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign video_encendido = video_q;
  assign pixel_tick      = tick_q;
  assign pixel_x         = pixel_x_q;
  assign pixel_y         = pixel_y_q;

`ifdef VGA_FIN_CUADRO_EN
  logic fin_cuadro_q, fin_cuadro_d;

  // High in the last clk of the last pixel of the frame.
  always_comb begin
    fin_cuadro_d = tick_d && (pixel_x_d == H_LAST) && (pixel_y_d == V_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fin_cuadro_q <= 1'b0;
    end else begin
      fin_cuadro_q <= fin_cuadro_d;
    end
  end

  assign fin_cuadro = fin_cuadro_q;
`endif

endmodule

// File: tb/tb_sincronizador_vga.sv
// Directed bench: default 640x480 timing over one line, plus a tiny 15x8 (DIV=3) raster
// for frame wrap, mid-sync reset and the optional VGA_FIN_CUADRO_EN strobe.
module tb_sincronizador_vga;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_f = 1'b1;
  logic reset_s = 1'b1;

  logic        f_hs, f_vs, f_ve, f_tick;
  logic [10:0] f_x, f_y;
  logic        s_hs, s_vs, s_ve, s_tick;
  logic [10:0] s_x, s_y;
`ifdef VGA_FIN_CUADRO_EN
  logic        f_fin, s_fin;
`endif

  sincronizador_vga dut_full (
    .clk             (clk),
    .reset           (reset_f),
    .hsync           (f_hs),
    .vsync           (f_vs),
    .video_encendido (f_ve),
    .pixel_tick      (f_tick),
    .pixel_x         (f_x),
    .pixel_y         (f_y)
`ifdef VGA_FIN_CUADRO_EN
    ,
    .fin_cuadro      (f_fin)
`endif
  );

  // Small raster: H 8+2+3+2=15, V 4+1+2+1=8, 3 clks per pixel, 360 clks per frame.
  sincronizador_vga #(
    .DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_small (
    .clk             (clk),
    .reset           (reset_s),
    .hsync           (s_hs),
    .vsync           (s_vs),
    .video_encendido (s_ve),
    .pixel_tick      (s_tick),
    .pixel_x         (s_x),
    .pixel_y         (s_y)
`ifdef VGA_FIN_CUADRO_EN
    ,
    .fin_cuadro      (s_fin)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic push_trace_div2();
    logic [10:0] xs [6] = '{11'd0, 11'd0, 11'd1, 11'd1, 11'd2, 11'd2};
    logic        ts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) exp_q.push_back({xs[i], ts[i]});
  endtask

  task automatic push_trace_div3();
    logic [10:0] xs [7] = '{11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd1, 11'd2};
    logic        ts [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) exp_q.push_back({xs[i], ts[i]});
  endtask

  task automatic small_startup(input string tag);
    logic [11:0] e;
    push_trace_div3();
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      check({tag, "_x"},    32'(s_x),    32'(e[11:1]));
      check({tag, "_tick"}, 32'(s_tick), 32'(e[0]));
      check({tag, "_y"},    32'(s_y),    32'd0);
      @(negedge clk);
    end
  endtask

  task automatic small_reset_hold(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check({tag, "_x"},  32'(s_x),    32'd0);
      check({tag, "_y"},  32'(s_y),    32'd0);
      check({tag, "_hs"}, 32'(s_hs),   32'd1);
      check({tag, "_vs"}, 32'(s_vs),   32'd1);
      check({tag, "_ve"}, 32'(s_ve),   32'd1);
      check({tag, "_tk"}, 32'(s_tick), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int hs_low, hs_first_x, hs_falls, ve_low, ve_first_x;
  int vs_low, vis_ticks, ticks, ve_bad, vs_bad, vs_midline, fin_cnt, fin_bad;
  logic prev_hs, prev_vs;
  logic [11:0] e;

  initial begin
    reset_f = 1'b1;
    reset_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_f_x",  32'(f_x),    32'd0);
      check("rst_f_y",  32'(f_y),    32'd0);
      check("rst_f_hs", 32'(f_hs),   32'd1);
      check("rst_f_vs", 32'(f_vs),   32'd1);
      check("rst_f_ve", 32'(f_ve),   32'd1);
      check("rst_f_tk", 32'(f_tick), 32'd0);
    end
    reset_f = 1'b0;

    // One full line of the default timing, clk 0..1599 after release.
    push_trace_div2();
    hs_low = 0; hs_first_x = -1; hs_falls = 0; ve_low = 0; ve_first_x = -1;
    prev_hs = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      if (k < 6) begin
        e = exp_q.pop_front();
        check("f_start_x",  32'(f_x),    32'(e[11:1]));
        check("f_start_tk", 32'(f_tick), 32'(e[0]));
      end
      if (!f_hs) begin
        hs_low++;
        if (hs_first_x < 0) hs_first_x = int'(f_x);
        if (prev_hs) hs_falls++;
      end
      if (!f_ve) begin
        ve_low++;
        if (ve_first_x < 0) ve_first_x = int'(f_x);
      end
      prev_hs = f_hs;
      if (k == 1599) begin
        check("f_last_x",  32'(f_x),    32'd799);
        check("f_last_y",  32'(f_y),    32'd0);
        check("f_last_tk", 32'(f_tick), 32'd1);
      end
      @(negedge clk);
    end
    check("f_wrap_x",    32'(f_x),   32'd0);
    check("f_wrap_y",    32'(f_y),   32'd1);
    check("f_wrap_hs",   32'(f_hs),  32'd1);
    check("f_wrap_ve",   32'(f_ve),  32'd1);
    check("f_hs_low",    32'(hs_low),     32'd192);
    check("f_hs_first",  32'(hs_first_x), 32'd656);
    check("f_hs_pulses", 32'(hs_falls),   32'd1);
    check("f_ve_low",    32'(ve_low),     32'd320);
    check("f_ve_first",  32'(ve_first_x), 32'd640);
    check("f_vs_line",   32'(f_vs),       32'd1);

    // Small raster: reset has been held since time 0.
    check("rst_s_x",  32'(s_x),  32'd0);
    check("rst_s_hs", 32'(s_hs), 32'd1);
    reset_s = 1'b0;
    small_startup("s_start");

    // Resync to release clk 0 by a fresh reset, then run one whole frame.
    reset_s = 1'b1;
    small_reset_hold("s_rst1");
    reset_s = 1'b0;
    vs_low = 0; vis_ticks = 0; ticks = 0; ve_bad = 0; vs_bad = 0; vs_midline = 0;
    fin_cnt = 0; fin_bad = 0;
    prev_vs = 1'b1;
    for (int k = 0; k < 360; k++) begin
      if (!s_vs) begin
        vs_low++;
        if (s_y < 11'd5 || s_y > 11'd6) vs_bad++;
      end
      if (s_vs != prev_vs && s_x != 11'd0) vs_midline++;
      prev_vs = s_vs;
      if (s_tick) begin
        ticks++;
        if (s_ve) vis_ticks++;
      end
      if (s_ve && s_y >= 11'd4) ve_bad++;
`ifdef VGA_FIN_CUADRO_EN
      if (s_fin) begin
        fin_cnt++;
        if (s_x != 11'd14 || s_y != 11'd7 || !s_tick) fin_bad++;
      end
`endif
      if (k == 357) check("s_y_last", 32'(s_y), 32'd7);
      if (k == 359) begin
        check("s_corner_x",  32'(s_x),    32'd14);
        check("s_corner_y",  32'(s_y),    32'd7);
        check("s_corner_tk", 32'(s_tick), 32'd1);
      end
      @(negedge clk);
    end
    check("s_frame_x",   32'(s_x),  32'd0);
    check("s_frame_y",   32'(s_y),  32'd0);
    check("s_frame_hs",  32'(s_hs), 32'd1);
    check("s_frame_vs",  32'(s_vs), 32'd1);
    check("s_frame_ve",  32'(s_ve), 32'd1);
    check("s_vs_low",    32'(vs_low),     32'd90);
    check("s_vs_rows",   32'(vs_bad),     32'd0);
    check("s_vs_midln",  32'(vs_midline), 32'd0);
    check("s_ticks",     32'(ticks),      32'd120);
    check("s_vis_ticks", 32'(vis_ticks),  32'd32);
    check("s_ve_rows",   32'(ve_bad),     32'd0);
`ifdef VGA_FIN_CUADRO_EN
    check("s_fin_cnt",   32'(fin_cnt),    32'd1);
    check("s_fin_pos",   32'(fin_bad),    32'd0);
    check("f_fin_idle",  32'(f_fin),      32'd0);
`endif

    // Walk to pixel (12,6), inside both sync pulses, one clk into its period.
    repeat (307) @(negedge clk);
    check("s_mid_x",  32'(s_x),  32'd12);
    check("s_mid_y",  32'(s_y),  32'd6);
    check("s_mid_hs", 32'(s_hs), 32'd0);
    check("s_mid_vs", 32'(s_vs), 32'd0);
    check("s_mid_tk", 32'(s_tick), 32'd0);
    reset_s = 1'b1;
    small_reset_hold("s_rst2");
    reset_s = 1'b0;
    small_startup("s_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
